// File: rtl/systolic_fp_int_array.sv
// systolic_fp_int_array: NxN output-stationary FP16 x bit-serial INT MAC array; ports: clk, rst (async high), active, precision, act_in[N], w_in[N], exp_set -> done, exp_out[N*N], acc_out[N*N]
module systolic_fp_int_array #(
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic [3:0] precision,
  input  logic [ACT_WIDTH-1:0] act_in [N],
  input  logic w_in [N],
  input  logic [4:0] exp_set,
  output logic done,
  output logic [4:0] exp_out [N*N],
  output logic signed [ACC_WIDTH-1:0] acc_out [N*N]
);
  logic [ACT_WIDTH-1:0] a_sk [N];
  logic w_sk [N];
  logic v_sk [N];
  logic [ACT_WIDTH-1:0] a_g [N][N];
  logic w_g [N][N];
  logic v_g [N][N];
  logic last_vq, vq_d, act_d;
  logic [3:0] p, pm1;
  assign p = (precision == 4'd0) ? 4'd1 : precision;
  assign pm1 = p - 4'd1;
  // Skew: row i activations and column i weight/valid are delayed by i cycles.
  for (genvar i = 0; i < N; i++) begin : g_sk
    if (i == 0) begin : g_z
      assign a_sk[i] = act_in[i];
      assign w_sk[i] = w_in[i];
      assign v_sk[i] = active;
    end else begin : g_d
      logic [ACT_WIDTH-1:0] a_d [i];
      logic w_d [i];
      logic v_d [i];
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            a_d[d] <= '0;
            w_d[d] <= 1'b0;
            v_d[d] <= 1'b0;
          end
        end else begin
          a_d[0] <= act_in[i];
          w_d[0] <= w_in[i];
          v_d[0] <= active;
          for (int d = 1; d < i; d++) begin
            a_d[d] <= a_d[d-1];
            w_d[d] <= w_d[d-1];
            v_d[d] <= v_d[d-1];
          end
        end
      assign a_sk[i] = a_d[i-1];
      assign w_sk[i] = w_d[i-1];
      assign v_sk[i] = v_d[i-1];
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      logic [ACT_WIDTH-1:0] a_r, a_src;
      logic w_r, v_r, v_q, w_src, v_src, start;
      logic [3:0] k, kk;
      logic [4:0] e_q, es, eff;
      logic [6:0] s;
      logic [ACC_WIDTH-1:0] acc, m, mag, al, pp;
      if (j == 0) begin : g_al
        assign a_src = a_sk[i];
      end else begin : g_an
        assign a_src = a_g[i][j-1];
      end
      if (i == 0) begin : g_wt
        assign w_src = w_sk[j];
        assign v_src = v_sk[j];
      end else begin : g_wn
        assign w_src = w_g[i-1][j];
        assign v_src = v_g[i-1][j];
      end
      // A pass starts on the first valid cycle after an idle one.
      always_comb begin
        start = v_r & ~v_q;
        kk = start ? 4'd0 : k;
        es = start ? exp_set : e_q;
        eff = (a_r[14:10] == 5'd0) ? 5'd1 : a_r[14:10];
        s = {2'b0, eff} - {2'b0, es};
        m = ACC_WIDTH'({a_r[14:10] != 5'd0, a_r[9:0]});
        mag = s[6] ? m >> 6'(-s) : m << s[5:0];
        al = a_r[15] ? -mag : mag;
        pp = !w_r ? '0 : (kk == pm1) ? -(al << kk) : al << kk;
      end
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          a_r <= '0;
          w_r <= 1'b0;
          v_r <= 1'b0;
          v_q <= 1'b0;
          k <= 4'd0;
          e_q <= 5'd0;
          acc <= '0;
        end else begin
          a_r <= a_src;
          w_r <= w_src;
          v_r <= v_src;
          v_q <= v_r;
          if (v_r) begin
            acc <= start ? pp : acc + pp;
            k <= (kk == pm1) ? 4'd0 : kk + 4'd1;
            e_q <= es;
          end
        end
      assign a_g[i][j] = a_r;
      assign w_g[i][j] = w_r;
      assign v_g[i][j] = v_r;
      assign acc_out[i*N+j] = acc;
      assign exp_out[i*N+j] = e_q;
      if (i == N-1 && j == N-1) begin : g_last
        assign last_vq = v_q;
      end
    end
  end
  // done follows the fall of the last PE's processed valid by one cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      act_d <= 1'b0;
      vq_d <= 1'b0;
      done <= 1'b0;
    end else begin
      act_d <= active;
      vq_d <= last_vq;
      done <= (active & ~act_d) ? 1'b0 : (done | (vq_d & ~last_vq));
    end
endmodule

// File: tb/tb_systolic_fp_int_array.sv
// tb_systolic_fp_int_array: directed self-checking bench for the 2x2 FP-INT systolic array
module tb_systolic_fp_int_array;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic active = 1'b0;
  logic [3:0] precision = 4'd4;
  logic [15:0] act_in [N];
  logic w_in [N];
  logic [4:0] exp_set = 5'd15;
  logic done;
  logic [4:0] exp_out [N*N];
  logic signed [31:0] acc_out [N*N];
  int checks = 0;
  int errors = 0;
  systolic_fp_int_array #(.ACT_WIDTH(16), .ACC_WIDTH(32), .N(N)) dut (
    .clk(clk), .rst(rst), .active(active), .precision(precision),
    .act_in(act_in), .w_in(w_in), .exp_set(exp_set),
    .done(done), .exp_out(exp_out), .acc_out(acc_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [15:0] a0, input logic [15:0] a1, input logic b0, input logic b1);
    act_in[0] = a0;
    act_in[1] = a1;
    w_in[0] = b0;
    w_in[1] = b1;
    active = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    active = 1'b0;
    w_in[0] = 1'b0;
    w_in[1] = 1'b0;
    act_in[0] = '0;
    act_in[1] = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    act_in[0] = '0;
    act_in[1] = '0;
    w_in[0] = 1'b0;
    w_in[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      active = ~active;
      w_in[0] = 1'b1;
      act_in[0] = 16'h3c00;
      @(posedge clk);
      #1;
    end
    for (int q = 0; q < N*N; q++) begin
      chk($sformatf("rst_acc%0d", q), acc_out[q], 32'd0);
      chk($sformatf("rst_exp%0d", q), 32'(exp_out[q]), 32'd0);
    end
    chk("rst_done", 32'(done), 32'd0);
    idle(1);
    rst = 1'b0;
    idle(1);
    // weight -1 on 1.0, then weight +1 on 3.0 / 2.0
    precision = 4'd4;
    exp_set = 5'd15;
    for (int c = 0; c < 4; c++) step(16'h3c00, 16'h0000, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) step(16'h4200, 16'h4000, c == 0, 1'b0);
    active = 1'b0;
    w_in[0] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("done_t%0d", c), 32'(done), (c == 5) ? 32'd1 : 32'd0);
    end
    chk("a_acc0", acc_out[0], 32'd2048);
    chk("a_exp0", 32'(exp_out[0]), 32'd15);
    chk("a_acc1", acc_out[1], 32'd0);
    chk("a_acc2", acc_out[2], 32'd2048);
    chk("a_exp2", 32'(exp_out[2]), 32'd15);
    chk("a_acc3", acc_out[3], 32'd0);
    idle(2);
    chk("done_hold", 32'(done), 32'd1);
    // denormal shifted out entirely
    step(16'h0010, 16'h0000, 1'b1, 1'b0);
    chk("done_clr", 32'(done), 32'd0);
    for (int c = 1; c < 4; c++) step(16'h0010, 16'h0000, 1'b0, 1'b0);
    idle(6);
    chk("dn_acc0", acc_out[0], 32'd0);
    // denormal with matching exponent
    exp_set = 5'd1;
    for (int c = 0; c < 4; c++) step(16'h0010, 16'h0000, c == 0, 1'b0);
    idle(6);
    chk("dn1_acc0", acc_out[0], 32'd16);
    chk("dn1_exp0", 32'(exp_out[0]), 32'd1);
    // -1.0 and 1.0 shifted down one place, weights +3 and +1
    exp_set = 5'd16;
    for (int c = 0; c < 4; c++) step(16'hbc00, 16'h3c00, c < 2, c == 0);
    idle(6);
    chk("neg_acc0", acc_out[0], -32'sd1536);
    chk("neg_exp0", 32'(exp_out[0]), 32'd16);
    chk("neg_acc1", acc_out[1], -32'sd512);
    chk("neg_acc2", acc_out[2], 32'd1536);
    chk("neg_acc3", acc_out[3], 32'd512);
    // precision 0 acts as 1: every set bit is -1
    precision = 4'd0;
    exp_set = 5'd15;
    for (int c = 0; c < 2; c++) step(16'h3c00, 16'h0000, 1'b1, 1'b0);
    idle(6);
    chk("p0_acc0", acc_out[0], -32'sd2048);
    // P=3 with a trailing partial group: bits 1,0,1 then 1
    precision = 4'd3;
    for (int c = 0; c < 4; c++) step(16'h3c00, 16'h0000, c != 1, 1'b0);
    idle(6);
    chk("p3_acc0", acc_out[0], -32'sd2048);
    chk("p3_done", 32'(done), 32'd1);
    // reset in the middle of a pass
    precision = 4'd4;
    for (int c = 0; c < 3; c++) step(16'h3c00, 16'h4000, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_acc0", acc_out[0], 32'd0);
    chk("mid_acc3", acc_out[3], 32'd0);
    chk("mid_exp0", 32'(exp_out[0]), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(6);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_acc2", acc_out[2], 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
